// File: rtl/decode_stage_if.sv
// Handshake and bundle bus between fetch, writeback and execute around decode_stage.
// The stage uses the slave view; the environment or neighbouring stages use the master view.
interface decode_stage_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_INST_WIDTH = 32,
    parameter int REG_WIDTH      = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [BUS_INST_WIDTH-1:0] in_inst;
    logic [BUS_DATA_WIDTH-1:0] in_pc;
    logic                      wb_en;
    logic [4:0]                wb_rd;
    logic [REG_WIDTH-1:0]      wb_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [BUS_DATA_WIDTH-1:0] out_pc;
    logic [REG_WIDTH-1:0]      out_valA;
    logic [REG_WIDTH-1:0]      out_valB;
    logic [REG_WIDTH-1:0]      out_simm;
    logic [1:0]                out_op;
    logic [2:0]                out_op2;
    logic [5:0]                out_op3;
    logic [3:0]                out_cond;
    logic                      out_a;
    logic                      out_i;
    logic [4:0]                out_rd;
    logic [21:0]               out_disp22;
    logic [29:0]               out_disp30;
    logic                      out_wr;
    logic [4:0]                out_dest;
    logic                      hazard;

    modport master (
        output in_valid, in_inst, in_pc, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_valA, out_valB, out_simm,
               out_op, out_op2, out_op3, out_cond, out_a, out_i, out_rd,
               out_disp22, out_disp30, out_wr, out_dest, hazard
    );

    modport slave (
        input  in_valid, in_inst, in_pc, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_valA, out_valB, out_simm,
               out_op, out_op2, out_op3, out_cond, out_a, out_i, out_rd,
               out_disp22, out_disp30, out_wr, out_dest, hazard
    );
endinterface

// File: rtl/decode_stage.sv
// SPARC decode stage: register file read, scoreboard hazard check, registered field-split bundle.
// Optional DECODE_BYPASS_EN forwards the same-cycle writeback into operands and hazard checks.
module decode_stage #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_INST_WIDTH = 32,
    parameter int REG_WIDTH      = 32,
    parameter int NUM_REGS       = 32
) (
    input  logic         clk,
    input  logic         reset,
    decode_stage_if.slave bus
);

    logic [31:0]          inst_s;
    logic [1:0]           op_s;
    logic [2:0]           op2_s;
    logic [5:0]           op3_s;
    logic                 i_s;
    logic [4:0]           rd_s;
    logic [4:0]           rs1_s;
    logic [4:0]           rs2_s;
    logic [4:0]           rb_idx_s;
    logic                 use_rs1_s;
    logic                 use_rs2_s;
    logic                 use_rd_src_s;
    logic                 has_dest_s;
    logic [4:0]           dest_s;
    logic                 wr_s;
    logic [REG_WIDTH-1:0] val_a_s;
    logic [REG_WIDTH-1:0] val_b_s;
    logic [REG_WIDTH-1:0] simm_s;
    logic [NUM_REGS-1:0]  wb_mask_s;
    logic [NUM_REGS-1:0]  set_mask_s;
    logic [NUM_REGS-1:0]  sb_eff_s;
    logic [NUM_REGS-1:0]  sb_next_s;
    logic                 hazard_raw_s;
    logic                 in_ready_s;
    logic                 accept_s;

    logic [REG_WIDTH-1:0]      rf_r [NUM_REGS];
    logic [NUM_REGS-1:0]       sb_r;
    logic                      valid_r;
    logic [BUS_DATA_WIDTH-1:0] pc_r;
    logic [REG_WIDTH-1:0]      val_a_r;
    logic [REG_WIDTH-1:0]      val_b_r;
    logic [REG_WIDTH-1:0]      simm_r;
    logic [1:0]                op_r;
    logic [2:0]                op2_r;
    logic [5:0]                op3_r;
    logic [3:0]                cond_r;
    logic                      a_r;
    logic                      i_r;
    logic [4:0]                rd_r;
    logic [21:0]               disp22_r;
    logic [29:0]               disp30_r;
    logic                      wr_r;
    logic [4:0]                dest_r;

    assign inst_s = bus.in_inst[31:0];
    assign op_s   = inst_s[31:30];
    assign op2_s  = inst_s[24:22];
    assign op3_s  = inst_s[24:19];
    assign i_s    = inst_s[13];
    assign rd_s   = inst_s[29:25];
    assign rs1_s  = inst_s[18:14];
    assign rs2_s  = inst_s[4:0];
    assign simm_s = {{(REG_WIDTH-13){inst_s[12]}}, inst_s[12:0]};

    assign use_rs1_s    = op_s[1];
    assign use_rs2_s    = op_s[1] && !i_s;
    assign use_rd_src_s = (op_s == 2'b11) && op3_s[2];
    // Immediate-form stores return the stored register on the B operand path
    assign rb_idx_s     = (use_rd_src_s && i_s) ? rd_s : rs2_s;

    // Destination register selection by instruction format
    always_comb begin
        has_dest_s = 1'b0;
        dest_s     = 5'd0;
        case (op_s)
            2'b00: begin
                if (op2_s == 3'b100) begin
                    has_dest_s = 1'b1;
                    dest_s     = rd_s;
                end else begin
                    has_dest_s = 1'b0;
                end
            end
            2'b01: begin
                has_dest_s = 1'b1;
                dest_s     = 5'd15;
            end
            2'b10: begin
                has_dest_s = 1'b1;
                dest_s     = rd_s;
            end
            2'b11: begin
                if (!op3_s[2]) begin
                    has_dest_s = 1'b1;
                    dest_s     = rd_s;
                end else begin
                    has_dest_s = 1'b0;
                end
            end
            default: begin
                has_dest_s = 1'b0;
                dest_s     = 5'd0;
            end
        endcase
    end

    assign wr_s = has_dest_s && (dest_s != 5'd0);

    // Writeback and accept masks feeding the scoreboard
    always_comb begin
        wb_mask_s  = '0;
        set_mask_s = '0;
        if (bus.wb_en) begin
            wb_mask_s[bus.wb_rd] = 1'b1;
        end else begin
            wb_mask_s = '0;
        end
        if (accept_s && wr_s) begin
            set_mask_s[dest_s] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
    end

`ifdef DECODE_BYPASS_EN
    assign sb_eff_s = sb_r & ~wb_mask_s;
`else
    assign sb_eff_s = sb_r;
`endif

    // A set on accept overrides a same-cycle clear on the same register
    assign sb_next_s = (sb_r & ~wb_mask_s) | set_mask_s;

    assign hazard_raw_s = (use_rs1_s    && sb_eff_s[rs1_s]) ||
                          (use_rs2_s    && sb_eff_s[rs2_s]) ||
                          (use_rd_src_s && sb_eff_s[rd_s])  ||
                          (wr_s         && sb_eff_s[dest_s]);

    assign in_ready_s = !reset && !hazard_raw_s && (!valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    // Operand read; r0 is hardwired to zero
    always_comb begin
        val_a_s = (rs1_s == 5'd0) ? '0 : rf_r[rs1_s];
        val_b_s = (rb_idx_s == 5'd0) ? '0 : rf_r[rb_idx_s];
`ifdef DECODE_BYPASS_EN
        if (bus.wb_en && (bus.wb_rd == rs1_s) && (rs1_s != 5'd0)) begin
            val_a_s = bus.wb_data;
        end else begin
            val_a_s = val_a_s;
        end
        if (bus.wb_en && (bus.wb_rd == rb_idx_s) && (rb_idx_s != 5'd0)) begin
            val_b_s = bus.wb_data;
        end else begin
            val_b_s = val_b_s;
        end
`endif
    end

    // Register file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                rf_r[k] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            rf_r[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Scoreboard of in-flight register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_r <= '0;
        end else begin
            sb_r <= sb_next_s;
        end
    end

    // Output bundle register; fields only change on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r  <= 1'b0;
            pc_r     <= '0;
            val_a_r  <= '0;
            val_b_r  <= '0;
            simm_r   <= '0;
            op_r     <= 2'd0;
            op2_r    <= 3'd0;
            op3_r    <= 6'd0;
            cond_r   <= 4'd0;
            a_r      <= 1'b0;
            i_r      <= 1'b0;
            rd_r     <= 5'd0;
            disp22_r <= 22'd0;
            disp30_r <= 30'd0;
            wr_r     <= 1'b0;
            dest_r   <= 5'd0;
        end else if (accept_s) begin
            valid_r  <= 1'b1;
            pc_r     <= bus.in_pc;
            val_a_r  <= val_a_s;
            val_b_r  <= val_b_s;
            simm_r   <= simm_s;
            op_r     <= op_s;
            op2_r    <= op2_s;
            op3_r    <= op3_s;
            cond_r   <= inst_s[28:25];
            a_r      <= inst_s[29];
            i_r      <= i_s;
            rd_r     <= rd_s;
            disp22_r <= inst_s[21:0];
            disp30_r <= inst_s[29:0];
            wr_r     <= wr_s;
            dest_r   <= dest_s;
        end else if (valid_r && bus.out_ready) begin
            valid_r  <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.hazard     = bus.in_valid && hazard_raw_s;
    assign bus.out_valid  = valid_r;
    assign bus.out_pc     = pc_r;
    assign bus.out_valA   = val_a_r;
    assign bus.out_valB   = val_b_r;
    assign bus.out_simm   = simm_r;
    assign bus.out_op     = op_r;
    assign bus.out_op2    = op2_r;
    assign bus.out_op3    = op3_r;
    assign bus.out_cond   = cond_r;
    assign bus.out_a      = a_r;
    assign bus.out_i      = i_r;
    assign bus.out_rd     = rd_r;
    assign bus.out_disp22 = disp22_r;
    assign bus.out_disp30 = disp30_r;
    assign bus.out_wr     = wr_r;
    assign bus.out_dest   = dest_r;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised SPARC decode stage sitting between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and reads operands from an internal register file. A per-register scoreboard detects RAW and WAW hazards against in-flight writes. The stage presents a registered, fully field-split instruction bundle to execute.

## Interface

Parameters:

- BUS_DATA_WIDTH, 64, PC width
- BUS_INST_WIDTH, 32, instruction width (fields decoded from bits [31:0])
- REG_WIDTH, 32, register/operand width
- NUM_REGS, 32, architectural registers; index width = $clog2(NUM_REGS), 5 at default

Ports:

- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  BUS_INST_WIDTH  instruction
- in_pc  in  BUS_DATA_WIDTH  PC+4 of instruction
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback register
- wb_data  in  REG_WIDTH  writeback value
- out_valid  out  1  bundle valid
- out_ready  in  1  execute consumes bundle
- out_pc  out  BUS_DATA_WIDTH  registered in_pc
- out_valA, out_valB  out  REG_WIDTH  rs1 / rs2 operand values
- out_simm  out  REG_WIDTH  imm13 sign-extended
- out_op[1:0], out_op2[2:0], out_op3[5:0], out_cond[3:0], out_a, out_i, out_rd[4:0], out_disp22[21:0], out_disp30[29:0]  out  SPARC fields, same bit positions as the instruction
- out_wr  out  1  instruction writes a register
- out_dest  out  5  destination register (15 for CALL)
- hazard  out  1  in_valid held off by scoreboard this cycle

## Operation

- Source registers:
  - rs1 = inst[18:14].
  - rs2 = inst[4:0], used only when op∈{2,3} and i=0.
  - rs1 is used for op∈{2,3}.
  - For op 3 stores (op3[2]=1), rd is also a source. Its value is returned on out_valA's companion path: out_valB carries rd's value when i=1.
- Destination:
  - op=2: dest = rd.
  - op=3 with op3[2]=0: dest = rd.
  - SETHI (op=0, op2=4): dest = rd.
  - CALL (op=1): dest = 15.
  - All other instructions have no destination.
  - dest=0 forces out_wr=0.
- Register file:
  - NUM_REGS×REG_WIDTH.
  - Read of r0 returns 0.
  - Written at posedge when wb_en && wb_rd≠0.
- Scoreboard, one bit per register:
  - Set on accept for dest when out_wr.
  - Cleared on wb_en for wb_rd.
  - If set and clear hit the same register in one cycle, set wins.
- hazard = in_valid && (any used source or dest has its scoreboard bit set).
  - Checking dest as well stalls WAW hazards, so at most one write per register is ever in flight.
- in_ready = !hazard_raw && (!out_valid || out_ready), where hazard_raw is the same check without in_valid.
- Accept = in_valid && in_ready. On accept, the output register loads all fields, operands and in_pc, and out_valid becomes 1.
- If out_ready && out_valid && no accept, out_valid becomes 0.
- If out_valid && !out_ready, every out_* field is held stable.

## Timing

- Reset, effective at the first posedge with reset=1:
  - out_valid=0.
  - All out_* fields = 0; hazard=0.
  - Scoreboard cleared; all registers = 0.
  - in_ready=1 from the cycle after reset deasserts.
- Latency: accept at edge N → bundle valid after edge N; full throughput is 1 instruction per cycle when out_ready=1.
- Writeback without bypass: a wb at edge N clears the bit. A dependent instruction is accepted no earlier than edge N+1 and reads the new value from the register file.
- A hazard stall holds in_ready=0 without altering out_* fields.
- Reset asserted mid-stream discards the bundle and scoreboard state; in-flight writebacks that arrive later still write the register file.

## Configuration

- DECODE_BYPASS_EN defined:
  - A source whose scoreboard bit is set but matches wb_rd with wb_en this cycle is not a hazard.
  - Its operand is taken from wb_data in the same cycle, so a dependent instruction is accepted at the same edge as the writeback (zero-bubble).
  - A dest match with wb is also treated as cleared.
- DECODE_BYPASS_EN undefined: no forwarding; a dependent instruction incurs at least one stall cycle after the writeback.

## Test plan

- Reset, then `add r3,r1,r2` (0x86004002) with r1=5, r2=7 → out_valid after 1 edge; out_valA=5, out_valB=7, out_dest=3, out_wr=1.
- Accept `add r3,…`, then `sub r4,r3,r1` with no wb → hazard=1, in_ready=0. wb_en r3=0x20 follows:
  - Bypass off: accept 1 cycle after the wb, out_valA=0x20.
  - Bypass on: accept on the same cycle as the wb, out_valA=0x20.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0; out_* held constant; the next instruction is accepted on the cycle out_ready rises.
- `call` → out_dest=15, out_wr=1, scoreboard bit 15 set. An instruction with `i=1, imm13=0x1FFF` → out_simm=0xFFFFFFFF and rs2 is ignored (no hazard on inst[4:0]).
- Accept `ld [r1], r5`, then another `ld …, r5` → WAW stall until wb r5. A wb to r0 leaves r0 reading 0.
- Assert reset with 2 registers pending → out_valid=0, hazard=0, and a dependent instruction is accepted on the cycle after reset deasserts.
